// File: rtl/vec_commit_rob.sv
// In-order commit/reorder buffer for vector commands.
// Hands out an issue number per accepted command, collects per-lane
// completion strobes, and retires entries strictly in issue order,
// one per cycle, with a registered retire pulse.
//
// Handshake: O_Alloc_Ack is a combinational accept of I_Alloc_Req; a
// request is consumed at the clock edge where both are high, and a
// refused request must be held or re-presented by the issuer.
module vec_commit_rob #(
  parameter int NUM_ENTRY = 8,
  parameter int NUM_LANES = 16,
  parameter int WIDTH_NO  = $clog2(NUM_ENTRY)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          I_Flush,
  input  logic                          I_Alloc_Req,
  input  logic [NUM_LANES-1:0]          I_En_Lane,
  output logic                          O_Alloc_Ack,
  output logic [WIDTH_NO-1:0]           O_Issue_No,
  input  logic [NUM_LANES-1:0]          I_Commit,
  input  logic [NUM_LANES*WIDTH_NO-1:0] I_Commit_No,
  output logic                          O_Retire,
  output logic [WIDTH_NO-1:0]           O_Retire_No,
  output logic                          O_Full,
  output logic                          O_Empty,
  output logic [WIDTH_NO:0]             O_Count,
  output logic                          O_Err
);

  localparam logic [WIDTH_NO:0]   CNT_ONE  = (WIDTH_NO+1)'(1);
  localparam logic [WIDTH_NO:0]   CNT_FULL = (WIDTH_NO+1)'(NUM_ENTRY);
  localparam logic [WIDTH_NO-1:0] PTR_ONE  = WIDTH_NO'(1);

  // Registered state
  logic [NUM_ENTRY-1:0] v_q, v_d;
  logic [NUM_LANES-1:0] en_q   [NUM_ENTRY];
  logic [NUM_LANES-1:0] en_d   [NUM_ENTRY];
  logic [NUM_LANES-1:0] done_q [NUM_ENTRY];
  logic [NUM_LANES-1:0] done_d [NUM_ENTRY];
  logic [WIDTH_NO-1:0]  head_q, head_d, tail_q, tail_d;
  logic [WIDTH_NO:0]    count_q, count_d;
  logic                 retire_q;
  logic [WIDTH_NO-1:0]  retire_no_q;
  logic                 err_q;

  // Lane decode
  logic [WIDTH_NO-1:0]  lane_no [NUM_LANES];
  logic [NUM_LANES-1:0] commit_ok, commit_bad;
  logic                 alloc_ack, head_complete, retire_now;

  assign alloc_ack = I_Alloc_Req & ~O_Full & ~I_Flush;

  // A commit lands only on a live entry, on one of its enabled lanes, and
  // never on the slot being (re)allocated this cycle; flush drops it silently.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lane_no[gi]    = I_Commit_No[gi*WIDTH_NO +: WIDTH_NO];
    assign commit_ok[gi]  = I_Commit[gi] & ~I_Flush & v_q[lane_no[gi]] &
                            en_q[lane_no[gi]][gi] &
                            ~(alloc_ack && (lane_no[gi] == tail_q));
    assign commit_bad[gi] = I_Commit[gi] & ~I_Flush & ~commit_ok[gi];
  end

  // Head is retirable once every enabled lane has reported done
  assign head_complete = v_q[head_q] & (&(done_q[head_q] | ~en_q[head_q]));
  assign retire_now    = head_complete & ~I_Flush;

  // Next-state for entries, pointers and count
  always_comb begin
    v_d     = v_q;
    en_d    = en_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int e = 0; e < NUM_ENTRY; e++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (commit_ok[i] && (lane_no[i] == WIDTH_NO'(e))) done_d[e][i] = 1'b1;
      end
    end
    if (retire_now) begin
      v_d[head_q]    = 1'b0;
      en_d[head_q]   = '0;
      done_d[head_q] = '0;
      head_d         = head_q + PTR_ONE;
    end
    if (alloc_ack) begin
      v_d[tail_q]    = 1'b1;
      en_d[tail_q]   = I_En_Lane;
      done_d[tail_q] = '0;
      tail_d         = tail_q + PTR_ONE;
    end
    if (alloc_ack && !retire_now) count_d = count_q + CNT_ONE;
    if (!alloc_ack && retire_now) count_d = count_q - CNT_ONE;
    if (I_Flush) begin
      v_d     = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int e = 0; e < NUM_ENTRY; e++) begin
        en_d[e]   = '0;
        done_d[e] = '0;
      end
    end
  end

  // State registers, retire pulse and sticky error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < NUM_ENTRY; e++) begin
        en_q[e]   <= '0;
        done_q[e] <= '0;
      end
      v_q         <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      retire_q    <= 1'b0;
      retire_no_q <= '0;
      err_q       <= 1'b0;
    end else begin
      en_q     <= en_d;
      done_q   <= done_d;
      v_q      <= v_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      retire_q <= retire_now;
      if (retire_now) retire_no_q <= head_q;
      if (|commit_bad) err_q <= 1'b1;
    end
  end

  assign O_Alloc_Ack = alloc_ack;
  assign O_Issue_No  = tail_q;
  assign O_Retire    = retire_q;
  assign O_Retire_No = retire_no_q;
  assign O_Full      = (count_q == CNT_FULL);
  assign O_Empty     = (count_q == '0);
  assign O_Count     = count_q;
  assign O_Err       = err_q;

endmodule

// File: tb/tb_vec_commit_rob.sv
// Directed bench for vec_commit_rob (NUM_ENTRY=8, NUM_LANES=16).
// Inputs change on the falling edge; combinational outputs are checked
// just after driving, registered outputs on the following falling edge.
module tb_vec_commit_rob;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_Flush, I_Alloc_Req;
  logic [15:0] I_En_Lane, I_Commit;
  logic [47:0] I_Commit_No;
  logic        O_Alloc_Ack, O_Retire, O_Full, O_Empty, O_Err;
  logic [2:0]  O_Issue_No, O_Retire_No;
  logic [3:0]  O_Count;

  int n_checks = 0;
  int n_fail   = 0;

  vec_commit_rob dut (
    .clock(clock), .reset(reset), .I_Flush(I_Flush), .I_Alloc_Req(I_Alloc_Req),
    .I_En_Lane(I_En_Lane), .O_Alloc_Ack(O_Alloc_Ack), .O_Issue_No(O_Issue_No),
    .I_Commit(I_Commit), .I_Commit_No(I_Commit_No), .O_Retire(O_Retire),
    .O_Retire_No(O_Retire_No), .O_Full(O_Full), .O_Empty(O_Empty),
    .O_Count(O_Count), .O_Err(O_Err)
  );

  // Clock
  always #5 clock = ~clock;

  typedef struct {
    logic        flush;
    logic        req;
    logic [15:0] en;
    logic [15:0] cm;
    logic [47:0] cno;
    logic        ack;
    logic [2:0]  ino;
    logic        ret;
    logic [2:0]  rno;
    logic [3:0]  cnt;
    logic        err;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic fl, input logic rq, input logic [15:0] en,
                              input logic [15:0] cm, input logic [47:0] cno,
                              input logic ack, input logic [2:0] ino, input logic ret,
                              input logic [2:0] rno, input logic [3:0] cnt,
                              input logic err);
    vec_t r;
    r.flush = fl; r.req = rq; r.en = en; r.cm = cm; r.cno = cno;
    r.ack = ack; r.ino = ino; r.ret = ret; r.rno = rno; r.cnt = cnt; r.err = err;
    return r;
  endfunction

  function automatic logic [47:0] cn_all(input logic [2:0] n);
    return {16{n}};
  endfunction

  function automatic logic [47:0] cn_split(input logic [2:0] lo, input logic [2:0] hi);
    return {{8{hi}}, {8{lo}}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic rq, input logic [15:0] en,
                       input logic [15:0] cm, input logic [47:0] cno);
    I_Flush = fl; I_Alloc_Req = rq; I_En_Lane = en; I_Commit = cm; I_Commit_No = cno;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_comb(input string tag, input logic ack, input logic [2:0] ino);
    #1;
    check({tag, ".ack"}, 32'(O_Alloc_Ack), 32'(ack));
    check({tag, ".issue_no"}, 32'(O_Issue_No), 32'(ino));
  endtask

  task automatic check_regs(input string tag, input logic ret, input logic [2:0] rno,
                            input logic [3:0] cnt, input logic err);
    check({tag, ".retire"}, 32'(O_Retire), 32'(ret));
    if (ret) check({tag, ".retire_no"}, 32'(O_Retire_No), 32'(rno));
    check({tag, ".count"}, 32'(O_Count), 32'(cnt));
    check({tag, ".full"}, 32'(O_Full), 32'(cnt == 4'd8));
    check({tag, ".empty"}, 32'(O_Empty), 32'(cnt == 4'd0));
    check({tag, ".err"}, 32'(O_Err), 32'(err));
  endtask

  initial begin
    // In-order retire, mixed-entry commits, partial lanes, flush, zero-lane alloc
    tbl[0]  = mk(0, 1, 16'hFFFF, 16'h0000, 48'h0,           1, 0, 0, 0, 1, 0);
    tbl[1]  = mk(0, 1, 16'hFFFF, 16'h0000, 48'h0,           1, 1, 0, 0, 2, 0);
    tbl[2]  = mk(0, 1, 16'hFFFF, 16'h0000, 48'h0,           1, 2, 0, 0, 3, 0);
    tbl[3]  = mk(0, 0, 16'h0000, 16'hFFFF, cn_all(1),       0, 3, 0, 0, 3, 0);
    tbl[4]  = mk(0, 0, 16'h0000, 16'hFFFF, cn_split(0, 2),  0, 3, 0, 0, 3, 0);
    tbl[5]  = mk(0, 0, 16'h0000, 16'hFF00, cn_all(0),       0, 3, 0, 0, 3, 0);
    tbl[6]  = mk(0, 0, 16'h0000, 16'h0000, 48'h0,           0, 3, 1, 0, 2, 0);
    tbl[7]  = mk(0, 0, 16'h0000, 16'h0000, 48'h0,           0, 3, 1, 1, 1, 0);
    tbl[8]  = mk(0, 0, 16'h0000, 16'h0000, 48'h0,           0, 3, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 16'h0000, 16'h00FF, cn_all(2),       0, 3, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 16'h0000, 16'h0000, 48'h0,           0, 3, 1, 2, 0, 0);
    tbl[11] = mk(0, 1, 16'h0005, 16'h0000, 48'h0,           1, 3, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 16'h0000, 16'h0002, cn_all(3),       0, 4, 0, 0, 1, 1);
    tbl[13] = mk(0, 0, 16'h0000, 16'h0005, cn_all(3),       0, 4, 0, 0, 1, 1);
    tbl[14] = mk(0, 0, 16'h0000, 16'h0000, 48'h0,           0, 4, 1, 3, 0, 1);
    tbl[15] = mk(0, 1, 16'hFFFF, 16'h0000, 48'h0,           1, 4, 0, 0, 1, 1);
    tbl[16] = mk(0, 1, 16'h00FF, 16'h0000, 48'h0,           1, 5, 0, 0, 2, 1);
    tbl[17] = mk(0, 1, 16'h000F, 16'h0000, 48'h0,           1, 6, 0, 0, 3, 1);
    tbl[18] = mk(0, 1, 16'hFFFF, 16'h0003, cn_all(4),       1, 7, 0, 0, 4, 1);
    tbl[19] = mk(1, 1, 16'hFFFF, 16'hFFFF, cn_all(5),       0, 0, 0, 0, 0, 1);
    tbl[20] = mk(0, 0, 16'h0000, 16'h0000, 48'h0,           0, 0, 0, 0, 0, 1);
    tbl[21] = mk(0, 1, 16'h0000, 16'h0000, 48'h0,           1, 0, 0, 0, 1, 1);
    tbl[22] = mk(0, 0, 16'h0000, 16'h0000, 48'h0,           0, 1, 1, 0, 0, 1);
    tbl[23] = mk(0, 0, 16'h0000, 16'h0000, 48'h0,           0, 1, 0, 0, 0, 1);

    // Reset
    reset = 1'b0;
    drive(0, 0, 16'h0, 16'h0, 48'h0);
    @(negedge clock);
    check_regs("reset", 1'b0, 3'd0, 4'd0, 1'b0);
    check("reset.retire_no", 32'(O_Retire_No), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Table
    for (int r = 0; r < 24; r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      drive(tbl[r].flush, tbl[r].req, tbl[r].en, tbl[r].cm, tbl[r].cno);
      check_comb(tag, tbl[r].ack, tbl[r].ino);
      tick();
      check_regs(tag, tbl[r].ret, tbl[r].rno, tbl[r].cnt, tbl[r].err);
    end
    // head = tail = 1, count 0, err 1

    // Asynchronous reset with five entries in flight and a retire pulse high
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 16'hFFFF, 16'h0, 48'h0);
      check_comb($sformatf("fill%0d", k), 1'b1, 3'(k + 1));
      tick();
      check("fill.count", 32'(O_Count), 32'(k + 1));
    end
    drive(0, 0, 16'h0, 16'hFFFF, cn_all(1));
    tick();
    check_regs("pre_rst_commit", 1'b0, 3'd0, 4'd5, 1'b1);
    drive(0, 1, 16'hFFFF, 16'h0, 48'h0);
    check_comb("pre_rst_alloc", 1'b1, 3'd6);
    tick();
    check_regs("pre_rst_retire", 1'b1, 3'd1, 4'd5, 1'b1);
    drive(0, 0, 16'h0, 16'h0, 48'h0);
    #2;
    reset = 1'b0;
    #1;
    check_regs("async_rst", 1'b0, 3'd0, 4'd0, 1'b0);
    check("async_rst.retire_no", 32'(O_Retire_No), 32'd0);
    check("async_rst.issue_no", 32'(O_Issue_No), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(0, 1, 16'hFFFF, 16'h0, 48'h0);
    check_comb("post_rst_alloc", 1'b1, 3'd0);
    tick();
    check_regs("post_rst_alloc", 1'b0, 3'd0, 4'd1, 1'b0);

    // Fill to full, hold a ninth request across the retire of entry 0
    for (int k = 1; k < 8; k++) begin
      drive(0, 1, 16'hFFFF, 16'h0, 48'h0);
      check_comb($sformatf("full%0d", k), 1'b1, 3'(k));
      tick();
    end
    check_regs("full", 1'b0, 3'd0, 4'd8, 1'b0);
    drive(0, 1, 16'hFFFF, 16'hFFFF, cn_all(0));
    check_comb("ninth_req", 1'b0, 3'd0);
    tick();
    check_regs("ninth_req", 1'b0, 3'd0, 4'd8, 1'b0);
    drive(0, 1, 16'hFFFF, 16'h0, 48'h0);
    check_comb("no_bypass", 1'b0, 3'd0);
    tick();
    check_regs("retire_while_full", 1'b1, 3'd0, 4'd7, 1'b0);
    check_comb("wrap_ack", 1'b1, 3'd0);
    tick();
    check_regs("wrap_ack", 1'b0, 3'd0, 4'd8, 1'b0);

    // Flush drops alloc and commits without flagging errors
    drive(1, 1, 16'hFFFF, 16'hFFFF, cn_all(1));
    check_comb("flush", 1'b0, 3'd1);
    tick();
    check_regs("flush", 1'b0, 3'd0, 4'd0, 1'b0);
    drive(1, 0, 16'h0, 16'h0001, cn_all(3));
    tick();
    check_regs("flush_bad_commit", 1'b0, 3'd0, 4'd0, 1'b0);
    // Commit aimed at the slot being allocated counts as invalid
    drive(0, 1, 16'hFFFF, 16'h0001, cn_all(0));
    check_comb("alloc_commit", 1'b1, 3'd0);
    tick();
    check_regs("alloc_commit", 1'b0, 3'd0, 4'd1, 1'b1);
    drive(0, 0, 16'h0, 16'hFFFF, cn_all(0));
    tick();
    check_regs("post_flush_commit", 1'b0, 3'd0, 4'd1, 1'b1);
    drive(0, 0, 16'h0, 16'h0, 48'h0);
    tick();
    check_regs("post_flush_retire", 1'b1, 3'd0, 4'd0, 1'b1);

    // Commit to an entry that was never allocated
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    drive(0, 0, 16'h0, 16'h0001, cn_all(2));
    tick();
    check_regs("invalid_commit", 1'b0, 3'd0, 4'd0, 1'b1);
    drive(0, 0, 16'h0, 16'h0, 48'h0);
    tick();
    check_regs("err_sticky", 1'b0, 3'd0, 4'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
